// File: rtl/aes_ctrl_multi.sv
// Round controller for the AES datapath: sequences single-round ops and the full
// AES-128/192/256 cipher, tracks round number and rcon, holds done until acknowledged.
package aes_pkg;
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;
endpackage

module aes_ctrl_multi #(
  parameter int         CNT_W     = 4,
  parameter logic [7:0] RCON_INIT = 8'h01,
  parameter bit         HAS_DEC   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  aes_pkg::opcode       opcode_i,
  input  logic [1:0]           key_len_i,
  input  logic                 dec_i,
  input  logic                 abort_i,
  input  logic                 ack_i,
  input  logic                 rcon_step_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 zero_rnd_o,
  output logic                 key_sel_o,
  output logic                 full_enc_o,
  output logic                 final_rnd_o,
  output logic                 en_rnd_o,
  output logic                 key_sub_o,
  output logic                 en_key_o,
  output logic                 gen_key_o,
  output logic                 next_rnd_o,
  output logic                 inv_o,
  output logic [CNT_W-1:0]     rnd_num_o,
  output logic [7:0]           rcon_o,
  output logic                 cipher_ready_o,
  output logic                 key_ready_o,
  output logic                 err_o
);
  import aes_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_SBOX, S_ROUND, S_DONE} state_e;

  state_e           state_q, state_d;
  opcode            op_q, op_d;
  logic [CNT_W-1:0] rnd_q, rnd_d, nr_q, nr_d, nr_sel;
  logic [7:0]       rcon_q, rcon_d;
  logic             inv_q, inv_d;
  logic             valid_op, accept, is_full, last_rnd;

  assign ready_o  = (state_q == S_IDLE) & ~rst;
  assign busy_o   = (state_q == S_SBOX) | (state_q == S_ROUND);
  assign valid_op = opcode_i inside {AESENC, AESENCLAST, AESKEYGENASSIST, AESENCFULL};
  assign accept   = start_i & ready_o & valid_op & (key_len_i != 2'b11);
  assign err_o    = start_i & ready_o & valid_op & (key_len_i == 2'b11);
  assign is_full  = (op_q == AESENCFULL);
  assign last_rnd = (rnd_q == nr_q);

  assign inv_o     = inv_q;
  assign rnd_num_o = rnd_q;
  assign rcon_o    = rcon_q;

  always_comb begin
    case (key_len_i)
      2'b00:   nr_sel = CNT_W'(10);
      2'b01:   nr_sel = CNT_W'(12);
      default: nr_sel = CNT_W'(14);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= NOOP;
      rnd_q   <= '0;
      nr_q    <= '0;
      rcon_q  <= RCON_INIT;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      rcon_q  <= rcon_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    rcon_d  = rcon_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d  = opcode_i;
        nr_d  = nr_sel;
        inv_d = HAS_DEC ? dec_i : 1'b0;
        if (opcode_i == AESENCFULL) begin
          rnd_d  = '0;
          rcon_d = RCON_INIT;
        end
        state_d = (opcode_i == AESKEYGENASSIST) ? S_ROUND : S_SBOX;
      end
      S_SBOX: begin
        if (is_full) rnd_d = rnd_q + CNT_W'(1);
        state_d = S_ROUND;
      end
      S_ROUND: state_d = (is_full && !last_rnd) ? S_SBOX : S_DONE;
      S_DONE:  if (ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // key_gen owns the rcon cadence; only honoured while an op is in flight
    if (busy_o && rcon_step_i)
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      rnd_d   = '0;
      rcon_d  = rcon_q;
    end
  end

  always_comb begin
    zero_rnd_o     = 1'b0;
    key_sel_o      = 1'b0;
    full_enc_o     = 1'b0;
    final_rnd_o    = 1'b0;
    en_rnd_o       = 1'b1;
    key_sub_o      = 1'b0;
    en_key_o       = 1'b1;
    gen_key_o      = 1'b0;
    next_rnd_o     = 1'b0;
    cipher_ready_o = 1'b0;
    key_ready_o    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        case (opcode_i)
          AESENCFULL: begin
            zero_rnd_o = 1'b1;
            key_sel_o  = 1'b1;
            key_sub_o  = 1'b1;
            full_enc_o = 1'b1;
          end
          AESKEYGENASSIST: en_rnd_o = 1'b0;
          default:         en_key_o = 1'b0;
        endcase
      end
      S_SBOX: begin
        full_enc_o = is_full;
        gen_key_o  = is_full;
      end
      S_ROUND: begin
        case (op_q)
          AESENCFULL: begin
            full_enc_o  = 1'b1;
            key_sub_o   = 1'b1;
            next_rnd_o  = 1'b1;
            final_rnd_o = last_rnd;
          end
          AESENC:          key_sel_o   = 1'b1;
          AESENCLAST:      final_rnd_o = 1'b1;
          AESKEYGENASSIST: gen_key_o   = 1'b1;
          default:         ;
        endcase
      end
      S_DONE: begin
        key_ready_o    = (op_q == AESKEYGENASSIST);
        cipher_ready_o = (op_q != AESKEYGENASSIST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_ctrl_multi.sv
// Directed + randomized bench for aes_ctrl_multi; expected timing and rcon values
// come from cycle-index formulas and a plain-arithmetic rcon model.
module tb_aes_ctrl_multi;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, dec_i, abort_i, ack_i, rcon_step_i;
  opcode       opcode_i;
  logic [1:0]  key_len_i;
  logic        ready_o, busy_o, zero_rnd_o, key_sel_o, full_enc_o, final_rnd_o, en_rnd_o;
  logic        key_sub_o, en_key_o, gen_key_o, next_rnd_o, inv_o;
  logic [3:0]  rnd_num_o;
  logic [7:0]  rcon_o;
  logic        cipher_ready_o, key_ready_o, err_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_rcon;

  always #5 clk = ~clk;

  aes_ctrl_multi dut (
    .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .key_len_i(key_len_i),
    .dec_i(dec_i), .abort_i(abort_i), .ack_i(ack_i), .rcon_step_i(rcon_step_i),
    .ready_o(ready_o), .busy_o(busy_o), .zero_rnd_o(zero_rnd_o), .key_sel_o(key_sel_o),
    .full_enc_o(full_enc_o), .final_rnd_o(final_rnd_o), .en_rnd_o(en_rnd_o),
    .key_sub_o(key_sub_o), .en_key_o(en_key_o), .gen_key_o(gen_key_o),
    .next_rnd_o(next_rnd_o), .inv_o(inv_o), .rnd_num_o(rnd_num_o), .rcon_o(rcon_o),
    .cipher_ready_o(cipher_ready_o), .key_ready_o(key_ready_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int xt(input int r);
    return ((r * 2) % 256) ^ ((r >= 128) ? 'h1b : 0);
  endfunction

  // Each cycle: inputs change at negedge, outputs sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0; ack_i = 1'b0; rcon_step_i = 1'b0;
  endtask

  task automatic run_full(input logic [1:0] kl, input int mode, input logic dec, input int abort_at);
    int nr = 10 + 2 * kl;
    int r  = 'h01;
    bit st, is_rnd;
    next_cycle();
    start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = kl; dec_i = dec;
    #1;
    chk("full_acc_ready", ready_o, 1);
    chk("full_acc_zks", {zero_rnd_o, key_sel_o, key_sub_o}, 3'b111);
    chk("full_acc_enkey", {en_key_o, en_rnd_o}, 2'b11);
    for (int c = 1; c <= 2 * nr; c++) begin
      is_rnd = (c % 2 == 0);
      next_cycle();
      start_i   = 1'($urandom_range(0, 1));
      opcode_i  = opcode'($urandom_range(1, 4));
      key_len_i = 2'($urandom_range(0, 3));
      case (mode)
        1:       st = is_rnd;
        2:       st = is_rnd && ((c / 2) % 2 == 0);
        3:       st = 1'($urandom_range(0, 1));
        default: st = 1'b0;
      endcase
      rcon_step_i = st;
      if (c == abort_at) begin
        abort_i = 1'b1; ack_i = 1'b1; rcon_step_i = 1'b1; st = 1'b0;
      end
      #1;
      chk("busy", busy_o, 1);
      chk("not_ready", ready_o, 0);
      chk("no_err_busy", err_o, 0);
      chk("no_done_busy", cipher_ready_o, 0);
      chk("rnd_num", rnd_num_o, is_rnd ? c / 2 : (c - 1) / 2);
      chk("rcon", rcon_o, r);
      if (is_rnd) begin
        chk("final_rnd", final_rnd_o, (c == 2 * nr));
        chk("round_ctl", {next_rnd_o, key_sub_o}, 2'b11);
      end else begin
        chk("sbox_ctl", {gen_key_o, key_sub_o}, 2'b10);
      end
      last_rcon = rcon_o;
      if (st) r = xt(r);
      if (c == abort_at) begin
        next_cycle(); #1;
        chk("abort_idle", {ready_o, busy_o, cipher_ready_o}, 3'b100);
        chk("abort_rnd", rnd_num_o, 0);
        chk("abort_rcon", rcon_o, r);
        return;
      end
    end
    next_cycle();
    start_i = 1'b1; opcode_i = AESENC; key_len_i = 2'b00;
    #1;
    chk("full_done", {cipher_ready_o, key_ready_o, ready_o, busy_o}, 4'b1000);
    chk("full_done_rnd", rnd_num_o, nr);
    chk("full_done_rcon", rcon_o, r);
    chk("full_done_inv", inv_o, dec);
    next_cycle(); ack_i = 1'b1; #1;
    chk("done_held_start", cipher_ready_o, 1);
    next_cycle(); #1;
    chk("after_ack", {ready_o, cipher_ready_o, busy_o}, 3'b100);
  endtask

  task automatic run_single(input opcode op, input int dcycles);
    int  lat = (op == AESKEYGENASSIST) ? 2 : 3;
    bit  kg  = (op == AESKEYGENASSIST);
    logic d  = 1'($urandom_range(0, 1));
    next_cycle();
    start_i = 1'b1; opcode_i = op; key_len_i = 2'($urandom_range(0, 2)); dec_i = d;
    #1;
    chk("single_acc_ready", ready_o, 1);
    chk("single_acc_en", {en_key_o, en_rnd_o}, kg ? 2'b10 : 2'b01);
    chk("single_acc_zero", zero_rnd_o, 0);
    for (int c = 1; c < lat; c++) begin
      next_cycle(); start_i = 1'($urandom_range(0, 1)); #1;
      chk("single_busy", {busy_o, ready_o, cipher_ready_o, key_ready_o}, 4'b1000);
    end
    for (int k = 1; k <= dcycles; k++) begin
      next_cycle(); ack_i = (k == dcycles); #1;
      chk("single_done", {key_ready_o, cipher_ready_o, ready_o, busy_o}, {kg, !kg, 2'b00});
      chk("single_done_en", {en_key_o, en_rnd_o}, 2'b11);
      chk("single_inv", inv_o, d);
    end
    next_cycle(); #1;
    chk("single_idle", {ready_o, key_ready_o, cipher_ready_o}, 3'b100);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; opcode_i = NOOP; key_len_i = 2'b00; dec_i = 1'b0;
    abort_i = 1'b0; ack_i = 1'b0; rcon_step_i = 1'b0;
    #1;
    chk("rst_flags", {ready_o, busy_o, cipher_ready_o, key_ready_o, err_o}, 5'b0);
    chk("rst_rnd", rnd_num_o, 0);
    chk("rst_rcon", rcon_o, 8'h01);
    chk("rst_en", {en_key_o, en_rnd_o, inv_o}, 3'b110);
    next_cycle(); rst = 1'b0; #1;
    chk("post_rst_ready", ready_o, 1);

    run_full(2'b00, 1, 1'b0, 0);
    chk("t1_rcon_last_round", last_rcon, 8'h36);
    run_full(2'b10, 2, 1'b1, 0);
    chk("t2_rcon_256_last_round", last_rcon, 8'h40);
    run_full(2'b01, 1, 1'b0, 0);
    chk("t2_rcon_192_last_round", last_rcon, 8'hd8);

    run_single(AESKEYGENASSIST, 5);
    run_single(AESENC, 1);
    run_single(AESENCLAST, 3);

    run_full(2'b00, 1, 1'b0, 7);
    run_full(2'b00, 3, 1'b0, 0);

    next_cycle(); start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = 2'b11; #1;
    chk("t5_err", {err_o, zero_rnd_o}, 2'b10);
    next_cycle(); #1;
    chk("t5_err_gone", {err_o, ready_o, busy_o}, 3'b010);
    next_cycle(); start_i = 1'b1; opcode_i = NOOP; key_len_i = 2'b00; #1;
    chk("noop_no_err", err_o, 0);
    next_cycle(); #1;
    chk("noop_idle", {ready_o, busy_o}, 2'b10);

    for (int i = 0; i < 6; i++) begin
      int kind = $urandom_range(0, 3);
      if (kind == 0) run_single(opcode'($urandom_range(1, 3)), $urandom_range(1, 4));
      else begin
        logic [1:0] kl = 2'($urandom_range(0, 2));
        int ab = (kind == 1) ? $urandom_range(1, 20) : 0;
        run_full(kl, 3, 1'($urandom_range(0, 1)), ab);
      end
    end

    next_cycle(); start_i = 1'b1; opcode_i = AESENCFULL; key_len_i = 2'b00; dec_i = 1'b1;
    for (int c = 1; c <= 4; c++) next_cycle();
    #1;
    chk("t6_pre_inv", {inv_o, busy_o}, 2'b11);
    rst = 1'b1; #1;
    chk("t6_flags", {ready_o, busy_o, cipher_ready_o, key_ready_o, err_o}, 5'b0);
    chk("t6_strobes", {final_rnd_o, next_rnd_o, key_sub_o, gen_key_o, zero_rnd_o}, 5'b0);
    chk("t6_state", {inv_o, en_key_o, en_rnd_o}, 3'b011);
    chk("t6_rnd_rcon", {rnd_num_o, rcon_o}, {4'd0, 8'h01});
    next_cycle(); rst = 1'b0; #1;
    chk("t6_ready", ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
